hazard_scoreboard: RTL

- Consumer of the per-instruction hazard descriptors that the instruction decoder emits at the D stage: source regs, T_use per source, T_new, destination A3.
- Holds a shifting record of in-flight writers for stages E, M and W.
- Decrements T_new as records advance.
- Produces the pipeline stall and all forwarding-mux selects for the 5-stage MIPS core.

---
 rtl/hazard_scoreboard_pkg.sv | 29 ++
 rtl/hazard_scoreboard_if.sv | 31 +++
 rtl/hazard_scoreboard_match.sv | 21 ++
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: forward-mux selects, stage ids and T_new classes.
package hazard_scoreboard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_E    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_W    = 2'b11;

    typedef enum logic [1:0] {
        STG_D = 2'b00,
        STG_E = 2'b01,
        STG_M = 2'b10,
        STG_W = 2'b11
    } stage_e;

    localparam int T_NEW_LOAD = 2;
    localparam int T_NEW_ALU  = 1;
    localparam int T_NEW_LINK = 0;

    // Youngest qualifying producer wins the forwarding mux.
    function automatic logic [1:0] fwd_pick(input logic hit_e, input logic hit_m,
                                            input logic hit_w);
        if (hit_e)      return FWD_E;
        else if (hit_m) return FWD_M;
        else if (hit_w) return FWD_W;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decoder-to-scoreboard bundle: D-stage hazard descriptor in, stall and forward selects out.
interface hazard_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int T_W   = 2
);
    import hazard_scoreboard_pkg::*;

    logic [REG_W-1:0] D_rs;
    logic [REG_W-1:0] D_rt;
    logic [T_W-1:0]   D_T_use_rs;
    logic [T_W-1:0]   D_T_use_rt;
    logic [T_W-1:0]   D_T_new;
    logic [REG_W-1:0] D_A3;
    logic             stall;
    logic [1:0]       fwd_D_rs;
    logic [1:0]       fwd_D_rt;
    logic [1:0]       fwd_E_rs;
    logic [1:0]       fwd_E_rt;
    logic             fwd_M_rt;

    modport master (
        output D_rs, D_rt, D_T_use_rs, D_T_use_rt, D_T_new, D_A3,
        input  stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt
    );

    modport slave (
        input  D_rs, D_rt, D_T_use_rs, D_T_use_rt, D_T_new, D_A3,
        output stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// One source-register vs one producer record: o_hit = {stall_hit, fwd_hit}.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int T_W   = 2
) (
    input  logic [REG_W-1:0] i_reg,
    input  logic [REG_W-1:0] i_a3,
    input  logic [T_W-1:0]   i_tnew,
    input  logic [T_W-1:0]   i_tuse,
    output logic [1:0]       o_hit
);

    logic w_match;

    // $0 is hard-wired, so it can never be a true dependency.
    assign w_match = (i_reg != '0) && (i_a3 == i_reg);
    assign o_hit   = {w_match && (i_tnew > i_tuse), w_match && (i_tnew == '0)};

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for the 5-stage MIPS pipeline; HAZARD_STAT_EN adds a stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int T_W   = 2
`ifdef HAZARD_STAT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
`ifdef HAZARD_STAT_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    hazard_scoreboard_if.slave bus
);

    localparam logic [T_W-1:0] T_ZERO = '0;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    logic [REG_W-1:0] r_rs_p1, r_rt_p1, r_a3_p1;
    logic [T_W-1:0]   r_tnew_p1;
    logic [REG_W-1:0] r_rt_p2, r_a3_p2;
    logic [T_W-1:0]   r_tnew_p2;
    logic [REG_W-1:0] r_a3_p3;

    logic [1:0] w_drs_e, w_drs_m, w_drs_w;
    logic [1:0] w_drt_e, w_drt_m, w_drt_w;
    logic [1:0] w_ers_m, w_ers_w, w_ert_m, w_ert_w;
    logic [1:0] w_mrt_w;
    logic       w_stall;
    logic       w_unused_stall_bits;

    // D-stage sources against E, M and W producers
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_drs_e (.i_reg(bus.D_rs), .i_a3(r_a3_p1), .i_tnew(r_tnew_p1), .i_tuse(bus.D_T_use_rs), .o_hit(w_drs_e));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_drs_m (.i_reg(bus.D_rs), .i_a3(r_a3_p2), .i_tnew(r_tnew_p2), .i_tuse(bus.D_T_use_rs), .o_hit(w_drs_m));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_drs_w (.i_reg(bus.D_rs), .i_a3(r_a3_p3), .i_tnew(T_ZERO),    .i_tuse(T_ZERO),         .o_hit(w_drs_w));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_drt_e (.i_reg(bus.D_rt), .i_a3(r_a3_p1), .i_tnew(r_tnew_p1), .i_tuse(bus.D_T_use_rt), .o_hit(w_drt_e));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_drt_m (.i_reg(bus.D_rt), .i_a3(r_a3_p2), .i_tnew(r_tnew_p2), .i_tuse(bus.D_T_use_rt), .o_hit(w_drt_m));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_drt_w (.i_reg(bus.D_rt), .i_a3(r_a3_p3), .i_tnew(T_ZERO),    .i_tuse(T_ZERO),         .o_hit(w_drt_w));

    // E-stage sources against M and W; M-stage store data against W
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_ers_m (.i_reg(r_rs_p1), .i_a3(r_a3_p2), .i_tnew(r_tnew_p2), .i_tuse(T_ZERO), .o_hit(w_ers_m));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_ers_w (.i_reg(r_rs_p1), .i_a3(r_a3_p3), .i_tnew(T_ZERO),    .i_tuse(T_ZERO), .o_hit(w_ers_w));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_ert_m (.i_reg(r_rt_p1), .i_a3(r_a3_p2), .i_tnew(r_tnew_p2), .i_tuse(T_ZERO), .o_hit(w_ert_m));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_ert_w (.i_reg(r_rt_p1), .i_a3(r_a3_p3), .i_tnew(T_ZERO),    .i_tuse(T_ZERO), .o_hit(w_ert_w));
    hazard_match #(.REG_W(REG_W), .T_W(T_W)) u_mrt_w (.i_reg(r_rt_p2), .i_a3(r_a3_p3), .i_tnew(T_ZERO),    .i_tuse(T_ZERO), .o_hit(w_mrt_w));

    // Only D-stage reads can stall, and a W producer is always ready.
    assign w_stall = w_drs_e[1] | w_drs_m[1] | w_drt_e[1] | w_drt_m[1];
    assign w_unused_stall_bits = ^{w_drs_w[1], w_drt_w[1], w_ers_m[1], w_ers_w[1],
                                   w_ert_m[1], w_ert_w[1], w_mrt_w[1]};

    assign bus.stall    = w_stall;
    assign bus.fwd_D_rs = fwd_pick(w_drs_e[0], w_drs_m[0], w_drs_w[0]);
    assign bus.fwd_D_rt = fwd_pick(w_drt_e[0], w_drt_m[0], w_drt_w[0]);
    assign bus.fwd_E_rs = fwd_pick(1'b0, w_ers_m[0], w_ers_w[0]);
    assign bus.fwd_E_rt = fwd_pick(1'b0, w_ert_m[0], w_ert_w[0]);
    assign bus.fwd_M_rt = w_mrt_w[0];

    // D -> E (bubble on stall), E -> M with T_new countdown, M -> W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs_p1   <= '0;
            r_rt_p1   <= '0;
            r_a3_p1   <= '0;
            r_tnew_p1 <= '0;
            r_rt_p2   <= '0;
            r_a3_p2   <= '0;
            r_tnew_p2 <= '0;
            r_a3_p3   <= '0;
        end else begin
            r_a3_p3   <= r_a3_p2;
            r_rt_p2   <= r_rt_p1;
            r_a3_p2   <= r_a3_p1;
            r_tnew_p2 <= sat_dec(r_tnew_p1);
            if (w_stall) begin
                r_rs_p1   <= '0;
                r_rt_p1   <= '0;
                r_a3_p1   <= '0;
                r_tnew_p1 <= '0;
            end else begin
                r_rs_p1   <= bus.D_rs;
                r_rt_p1   <= bus.D_rt;
                r_a3_p1   <= bus.D_A3;
                r_tnew_p1 <= bus.D_T_new;
            end
        end
    end

`ifdef HAZARD_STAT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
